// File: rtl/mul_radix16_sequencer_if.sv
// Handshake bundle for mul_radix16_sequencer.
//   Request side : in_valid_i / in_ready_o carrying op_i, rs1_i, rs2_i, tag_i
//   Control      : flush_i kills the in-flight operation, busy_o reports non-idle
//   Result side  : out_valid_o / out_ready_i carrying result_o, tag_o
// Signal suffixes are from the multiplier's point of view (the slave modport).
interface mul_radix16_sequencer_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [1:0]       op_i;
  logic [XLEN-1:0]  rs1_i;
  logic [XLEN-1:0]  rs2_i;
  logic [TAG_W-1:0] tag_i;
  logic             flush_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [XLEN-1:0]  result_o;
  logic [TAG_W-1:0] tag_o;
  logic             busy_o;

  modport master (
    output in_valid_i, op_i, rs1_i, rs2_i, tag_i, flush_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, tag_o, busy_o
  );

  modport slave (
    input  in_valid_i, op_i, rs1_i, rs2_i, tag_i, flush_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, tag_o, busy_o
  );
endinterface

// File: rtl/mul_radix16_sequencer.sv
// Iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU).
// Operands are converted to unsigned magnitudes on accept; one 4-bit
// multiplier digit is consumed per cycle, and its partial product is added
// into a 2*XLEN accumulator at weight 16^cnt. The sign is reapplied on the
// final step, and the requested half is registered together with the tag.
// Ports:
//   clk_i  - clock, rising edge
//   rst_ni - asynchronous active-low reset
//   bus    - request/result handshake, flush and busy (slave modport)
module mul_radix16_sequencer #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  mul_radix16_sequencer_if.slave      bus
);

  localparam int STEPS = XLEN / 4;
  localparam int CNT_W = $clog2(STEPS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b11;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e            state, state_next;
  logic [XLEN-1:0]   mcand, mplier;
  logic [2*XLEN-1:0] acc, acc_next, prod;
  logic [CNT_W-1:0]  cnt;
  logic              neg;
  logic [1:0]        op_q;
  logic [TAG_W-1:0]  tag_q, tag_out;
  logic [XLEN-1:0]   result_q;
  logic [XLEN+3:0]   pp;
  logic              accept, last_step, sign_a, sign_b;

  // Flush takes priority over a same-cycle request.
  assign accept    = (state == IDLE) && bus.in_valid_i && !bus.flush_i;
  assign last_step = (state == CALC) && (cnt == LAST_CNT);

  // MUL uses the signed path: the low half does not depend on signedness.
  assign sign_a = (bus.op_i != OP_MULHU) && bus.rs1_i[XLEN-1];
  assign sign_b = !bus.op_i[1] && bus.rs2_i[XLEN-1];

  // AND-array partial product of the current multiplier digit.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    pp = '0;
    for (int j = 0; j < 4; j++) begin
      if (mplier[j]) pp = pp + ({4'b0000, mcand} << j);
    end
  end

  assign acc_next = acc + ({{(XLEN-4){1'b0}}, pp} << {cnt, 2'b00});
  assign prod     = neg ? -acc_next : acc_next;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept) state_next = CALC;
      CALC: begin
        if (bus.flush_i)    state_next = IDLE;
        else if (last_step) state_next = DONE;
      end
      DONE: if (bus.out_ready_i || bus.flush_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      neg      <= 1'b0;
      op_q     <= OP_MUL;
      tag_q    <= '0;
      tag_out  <= '0;
      result_q <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples the pre-edge values, independent of statement order.
      state <= state_next;
      if (accept) begin
        mcand  <= sign_a ? -bus.rs1_i : bus.rs1_i;
        mplier <= sign_b ? -bus.rs2_i : bus.rs2_i;
        neg    <= sign_a ^ sign_b;
        acc    <= '0;
        cnt    <= '0;
        op_q   <= bus.op_i;
        tag_q  <= bus.tag_i;
      end else if (state == CALC && !bus.flush_i) begin
        acc    <= acc_next;
        mplier <= mplier >> 4;
        cnt    <= cnt + 1'b1;
        if (last_step) begin
          result_q <= (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
          tag_out  <= tag_q;
        end
      end
    end
  end

  // All outputs decode registered state only.
  assign bus.in_ready_o  = (state == IDLE);
  assign bus.out_valid_o = (state == DONE);
  assign bus.busy_o      = (state != IDLE);
  assign bus.result_o    = result_q;
  assign bus.tag_o       = tag_out;

endmodule

// File: doc/mul_radix16_sequencer.md
# mul_radix16_sequencer

Iterative 32-bit multiply unit for the RV32M MUL/MULH/MULHSU/MULHU group in the execute stage. It feeds one radix-16 (4-bit multiplier digit) partial-product array per cycle and accumulates shifted partial sums into a 2·XLEN-bit register. Operands are accepted over a valid/ready handshake, and the selected 32-bit half of the product is returned over a second valid/ready handshake with a tag. It is the shared multi-cycle multiplier between issue and writeback, and it is flushable on branch mispredict.

## Interface
- XLEN, 32: operand/result width; must be a multiple of 4.
- TAG_W, 6: width of the opaque tag carried with each operation (ROB index).
- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- in_valid_i  in  1  operation request.
- in_ready_o  out  1  unit can accept; high only in IDLE.
- op_i  in  2  00 MUL (low half), 01 MULH (s×s high), 10 MULHSU (s×u high), 11 MULHU (u×u high).
- rs1_i, rs2_i  in  XLEN  multiplicand, multiplier.
- tag_i  in  TAG_W  tag of request.
- flush_i  in  1  kill in-flight operation.
- out_valid_o  out  1  result available.
- out_ready_i  in  1  consumer accepts result.
- result_o  out  XLEN  selected product half.
- tag_o  out  TAG_W  tag of result.
- busy_o  out  1  state ≠ IDLE.

## Operation
- States: IDLE, CALC, DONE.
- IDLE → CALC on in_valid_i && in_ready_o && !flush_i (accept). On accept the unit latches the following:
  - sign_a = rs1_i[XLEN-1] when op ∈ {MUL, MULH, MULHSU}; sign_b = rs2_i[XLEN-1] when op ∈ {MUL, MULH}. Otherwise each is 0.
  - mcand = sign_a ? −rs1_i : rs1_i, and mplier = sign_b ? −rs2_i : rs2_i, both as XLEN-bit unsigned magnitudes. 0x80000000 maps to magnitude 2^31.
  - neg = sign_a ^ sign_b; acc = 0; cnt = 0; op and tag.
  - MUL low half is identical for signed and unsigned operands, so the signed path is used for MUL.
- CALC runs one step per cycle:
  - digit = mplier[3:0].
  - pp = Σ_{j=0..3} (digit[j] ? mcand << j : 0), XLEN+4 bits; this is the AND-array partial product.
  - acc += pp << (4·cnt), all arithmetic mod 2^(2·XLEN).
  - mplier >>= 4; cnt++.
- CALC → DONE on the step with cnt = XLEN/4−1. On that edge, result_o is loaded from p = neg ? −acc_next : acc_next (2's complement, 2·XLEN bits): p[XLEN-1:0] for MUL, otherwise p[2XLEN-1:XLEN]. tag_o is loaded in the same edge. There is no early termination, so latency is data-independent.
- DONE holds out_valid_o = 1 until out_valid_o && out_ready_i, then goes to IDLE. result_o and tag_o stay stable while stalled.
- flush_i (synchronous, any state): next state IDLE, out_valid_o = 0 next cycle, and no result is emitted.
  - flush_i beats an accept in the same cycle: the request is not taken.
  - flush_i in DONE with out_ready_i high: the handshake still completes this cycle, because the consumer sampled valid.
- Reset (asynchronous, any time including mid-CALC) clears the following:
  - state = IDLE, out_valid_o = 0, busy_o = 0, result_o = 0, tag_o = 0, acc = 0, cnt = 0.
  - in_ready_o = 1 once reset is released.

## Timing
- Accept at edge E. The XLEN/4 accumulation steps occur at edges E+1 … E+XLEN/4, which is 8 for XLEN=32. out_valid_o is high from edge E+XLEN/4 onward.
- Minimum spacing between accepts is XLEN/4+2 cycles: CALC, then one DONE handshake cycle, then IDLE.
- in_ready_o is a pure decode of state, with no combinational path from in_valid_i.
- out_valid_o, result_o and tag_o are registered. There is no combinational path from out_ready_i or flush_i to any output.

## Test plan
- MUL 7×6, tag 5: result_o = 0x0000002A and tag_o = 5, out_valid_o exactly 8 cycles after accept; in_ready_o low throughout.
- Signed/unsigned with rs1 = rs2 = 0xFFFFFFFF: MUL → 0x00000001; MULH → 0x00000000; MULHU → 0xFFFFFFFE; MULHSU → 0xFFFFFFFF.
- Corner magnitudes:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHSU rs1 = 0x80000000, rs2 = 0xFFFFFFFF → 0x80000000.
  - MUL 0×0xDEADBEEF → 0.
- Backpressure: hold out_ready_i low for 5 cycles in DONE. Required: result_o and tag_o unchanged and in_ready_o = 0. Raise out_ready_i: out_valid_o drops next cycle and in_ready_o rises.
- Flush:
  - flush_i on the 4th CALC cycle: out_valid_o never asserts, and in_ready_o = 1 next cycle. A following MULHU 0x10000×0x10000 returns 0x00000001.
  - flush_i together with in_valid_i in IDLE: not accepted.
- Async reset: assert rst_ni low mid-CALC, between clock edges. Required: out_valid_o = 0 and busy_o = 0 immediately. After release, a new MUL 3×3 → 9 with normal latency.
